// File: rtl/opcode_exec_unit.sv
// Opcode execution unit: 4-bit opcodes against a NUM_REGS-entry register file, valid/ready on both sides.
// Optional build macro SAT_ARITH_EN: ADD/SUB saturate instead of wrapping.
module opcode_exec_unit #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              carry,
  output logic              err
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [3:0] OP_PASS  = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_NOT   = 4'h3;
  localparam logic [3:0] OP_ADD   = 4'h4;
  localparam logic [3:0] OP_SUB   = 4'h5;
  localparam logic [3:0] OP_AND   = 4'h6;
  localparam logic [3:0] OP_OR    = 4'h7;
  localparam logic [3:0] OP_XOR   = 4'h8;
  localparam logic [3:0] OP_SHL   = 4'h9;
  localparam logic [3:0] OP_SHR   = 4'hA;
  localparam logic [3:0] OP_MUL   = 4'hB;
  localparam logic [3:0] OP_ERR   = 4'hF;

  typedef enum logic {IDLE, MUL_BUSY} state_t;
  state_t state, state_next;

  // Handshake: an instruction is taken on in_valid && in_ready; a result beat
  // completes on out_valid && out_ready and is held unchanged until then.
  logic accept;
  logic mul_done;
  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] operand;
  assign operand = regs[addr];

  logic [DATA_W-1:0] acc, mcand, mplier, mul_add;
  logic [CNT_W-1:0]  cnt;
  assign mul_done = (state == MUL_BUSY) && (cnt == CNT_LAST);
  assign mul_add  = mplier[0] ? acc + mcand : acc;

  logic [DATA_W:0] sum, diff;
  assign sum  = {1'b0, data} + {1'b0, operand};
  assign diff = {1'b0, data} - {1'b0, operand};

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept && opcode == OP_MUL) state_next = MUL_BUSY;
      MUL_BUSY: if (mul_done) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  logic [DATA_W-1:0] op_result;
  logic              op_carry;
  logic              op_err;

  always_comb begin
    op_result = '0;
    op_carry  = 1'b0;
    op_err    = 1'b0;
    case (opcode)
      OP_PASS, OP_LOAD: op_result = data;
      OP_STORE:         op_result = operand;
      OP_NOT:           op_result = ~data;
      OP_ADD: begin
        op_carry = sum[DATA_W];
`ifdef SAT_ARITH_EN
        op_result = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
`else
        op_result = sum[DATA_W-1:0];
`endif
      end
      OP_SUB: begin
        op_carry = diff[DATA_W];
`ifdef SAT_ARITH_EN
        op_result = diff[DATA_W] ? '0 : diff[DATA_W-1:0];
`else
        op_result = diff[DATA_W-1:0];
`endif
      end
      OP_AND:  op_result = data & operand;
      OP_OR:   op_result = data | operand;
      OP_XOR:  op_result = data ^ operand;
      OP_SHL:  op_result = data << operand[SH_W-1:0];
      OP_SHR:  op_result = data >> operand[SH_W-1:0];
      OP_MUL:  op_result = '0;
      OP_ERR: begin
        op_result = '1;
        op_err    = 1'b1;
      end
      default: op_err = 1'b1;
    endcase
  end

  // MUL is shift-add, one multiplier bit per cycle; the final step's sum goes straight to result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      err       <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        if (opcode == OP_LOAD) regs[addr] <= data;
        if (opcode == OP_MUL) begin
          acc    <= '0;
          mcand  <= data;
          mplier <= operand;
          cnt    <= '0;
        end else begin
          out_valid <= 1'b1;
          result    <= op_result;
          zero      <= (op_result == '0);
          carry     <= op_carry;
          err       <= op_err;
        end
      end
      if (state == MUL_BUSY) begin
        acc    <= mul_add;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (mul_done) begin
          out_valid <= 1'b1;
          result    <= mul_add;
          zero      <= (mul_add == '0);
          carry     <= 1'b0;
          err       <= 1'b0;
          cnt       <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_opcode_exec_unit.sv
// Directed bench for opcode_exec_unit (DATA_W=8, NUM_REGS=4); expectations follow SAT_ARITH_EN if defined.
module tb_opcode_exec_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] opcode = 4'h0;
  logic [1:0] addr = 2'd0;
  logic [7:0] data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] result;
  logic       zero, carry, err;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  opcode_exec_unit #(.DATA_W(8), .NUM_REGS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .addr(addr), .data(data),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [1:0] a, input logic [7:0] d);
    int guard = 0;
    opcode = op; addr = a; data = d; in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) check("issue_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [3:0] op, input logic [1:0] a, input logic [7:0] d,
                       input logic [7:0] er, input logic ez, input logic ec, input logic ee);
    issue(op, a, d);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_result"}, 32'(result), 32'(er));
    check({tag, "_zero"}, 32'(zero), 32'(ez));
    check({tag, "_carry"}, 32'(carry), 32'(ec));
    check({tag, "_err"}, 32'(err), 32'(ee));
  endtask

  initial begin
    int edges;
    logic seen;
    logic [7:0] stream [4];
    stream[0] = 8'h11; stream[1] = 8'h22; stream[2] = 8'h33; stream[3] = 8'h44;

    // Reset state
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'({zero, carry, err}), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD with carry
    do_op("load_r2", 4'h1, 2'd2, 8'h0F, 8'h0F, 1'b0, 1'b0, 1'b0);
`ifdef SAT_ARITH_EN
    do_op("add_carry", 4'h4, 2'd2, 8'hF5, 8'hFF, 1'b0, 1'b1, 1'b0);
`else
    do_op("add_carry", 4'h4, 2'd2, 8'hF5, 8'h04, 1'b0, 1'b1, 1'b0);
`endif

    // SUB to zero and with borrow
    do_op("load_r1", 4'h1, 2'd1, 8'h03, 8'h03, 1'b0, 1'b0, 1'b0);
    do_op("sub_zero", 4'h5, 2'd1, 8'h03, 8'h00, 1'b1, 1'b0, 1'b0);
`ifdef SAT_ARITH_EN
    do_op("sub_borrow", 4'h5, 2'd1, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
`else
    do_op("sub_borrow", 4'h5, 2'd1, 8'h01, 8'hFE, 1'b0, 1'b1, 1'b0);
`endif

    // Logic and shift ops (r1=0x03, r2=0x0F)
    do_op("store_r2", 4'h2, 2'd2, 8'h00, 8'h0F, 1'b0, 1'b0, 1'b0);
    do_op("not", 4'h3, 2'd0, 8'h5A, 8'hA5, 1'b0, 1'b0, 1'b0);
    do_op("and", 4'h6, 2'd2, 8'hF0, 8'h00, 1'b1, 1'b0, 1'b0);
    do_op("or", 4'h7, 2'd2, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b0);
    do_op("shl", 4'h9, 2'd1, 8'h81, 8'h08, 1'b0, 1'b0, 1'b0);
    do_op("shr", 4'hA, 2'd1, 8'h81, 8'h10, 1'b0, 1'b0, 1'b0);
    do_op("load_r1b", 4'h1, 2'd1, 8'h77, 8'h77, 1'b0, 1'b0, 1'b0);
    do_op("store_r1b", 4'h2, 2'd1, 8'h00, 8'h77, 1'b0, 1'b0, 1'b0);

    // MUL 0x0B * 0x0D = 0x8F after 9 edges
    do_op("load_r3", 4'h1, 2'd3, 8'h0D, 8'h0D, 1'b0, 1'b0, 1'b0);
    issue(4'hB, 2'd3, 8'h0B);
    edges = 1;
    seen = 1'b0;
    while (!out_valid && edges < 30) begin
      if (in_ready) seen = 1'b1;
      @(posedge clk); #1;
      edges++;
    end
    check("mul_latency", 32'(edges), 32'd9);
    check("mul_busy_ready", 32'(seen), 32'd0);
    check("mul_result", 32'(result), 32'h8F);
    check("mul_flags", 32'({zero, carry, err}), 32'd0);

    // Backpressure on XOR result, queued PASS accepted on release
    do_op("load_r0", 4'h1, 2'd0, 8'h55, 8'h55, 1'b0, 1'b0, 1'b0);
    do_op("xor", 4'h8, 2'd0, 8'hAA, 8'hFF, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    opcode = 4'h0; addr = 2'd0; data = 8'h3C; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result", 32'(result), 32'hFF);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("queued_valid", 32'(out_valid), 32'd1);
    check("queued_result", 32'(result), 32'h3C);

    // Illegal and error opcodes
    do_op("illegal_c", 4'hC, 2'd0, 8'h12, 8'h00, 1'b1, 1'b0, 1'b1);
    do_op("err_f", 4'hF, 2'd0, 8'h12, 8'hFF, 1'b0, 1'b0, 1'b1);

    // Full-rate PASS stream
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      opcode = 4'h0; data = stream[i];
      check("stream_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_result", 32'(result), 32'(stream[i]));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("stream_drain", 32'(out_valid), 32'd0);

    // Reset mid-MUL: no result beat afterwards, regfile cleared
    issue(4'hB, 2'd3, 8'h0B);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_flags", 32'({zero, carry, err}), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_beat", 32'(seen), 32'd0);
    do_op("midrst_r3_cleared", 4'h2, 2'd3, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
